systolic_array_ctrl: RTL and testbench

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_enable_skew.sv | 32 +++
 rtl/systolic_array_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared state encoding and default sizing for the weight-stationary systolic array controller.
package sa_pkg;

  localparam int SA_ROWS_DEFAULT  = 4;
  localparam int SA_LEN_W_DEFAULT = 16;
  localparam int SA_PERF_W        = 32;

  typedef enum logic [2:0] {
    SA_IDLE,
    SA_CLEAR,
    SA_LOAD_W,
    SA_SETTLE,
    SA_COMPUTE,
    SA_DRAIN,
    SA_DONE
  } sa_state_e;

endpackage

// File: rtl/sa_enable_skew.sv
// Skewed MAC-enable chain: row r sees the row-0 enable delayed by r cycles,
// and the bottom row's enable delayed once more becomes the output-valid strobe.
module sa_enable_skew
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_clear,
  input  logic            i_en0,
  output logic [ROWS-1:0] o_enable,
  output logic            o_last
);

  logic [ROWS-1:0] r_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
    end else begin
      r_shift <= {r_shift[ROWS-2:0], i_en0};
    end
  end

  // Row 0 is combinational so it tracks the activation handshake in the same cycle.
  assign o_enable = {r_shift[ROWS-2:0], i_en0};
  assign o_last   = r_shift[ROWS-1];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a weight-stationary systolic array: clear, load weights, settle,
// stream activations, drain. Optional perf_cycles port under `SA_CTRL_PERF_CNT_EN`.
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS  = SA_ROWS_DEFAULT,
  parameter int LEN_W = SA_LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             wet_valid,
  output logic             wet_ready,
  input  logic             act_valid,
  output logic             act_ready,
  output logic             pe_clear_weight,
  output logic             pe_weight_sel,
  output logic [ROWS-1:0]  pe_mac_enable,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef SA_CTRL_PERF_CNT_EN
  ,
  output logic [SA_PERF_W-1:0] perf_cycles
`endif
);

  localparam int CNT_W = $clog2(ROWS + 2);

  sa_state_e        r_state;
  sa_state_e        w_nextState;
  logic [CNT_W-1:0] r_phaseCnt;
  logic [LEN_W-1:0] r_actCnt;
  logic [LEN_W-1:0] r_len;
  logic             r_err;
  logic             w_phaseInc;
  logic             w_startAcc;
  logic             w_setErr;
  logic             w_wetReady;
  logic             w_weightSel;
  logic             w_clear;
  logic             w_actReady;
  logic             w_en0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SA_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_phaseInc  = 1'b0;
    w_startAcc  = 1'b0;
    w_setErr    = 1'b0;
    w_wetReady  = 1'b0;
    w_weightSel = 1'b0;
    w_clear     = 1'b0;
    w_actReady  = 1'b0;
    case (r_state)
      SA_IDLE: begin
        if (start) begin
          w_startAcc  = 1'b1;
          w_nextState = (len == '0) ? SA_DONE : SA_CLEAR;
        end
      end
      SA_CLEAR: begin
        w_clear     = 1'b1;
        w_nextState = SA_LOAD_W;
      end
      SA_LOAD_W: begin
        w_wetReady  = 1'b1;
        w_weightSel = wet_valid;
        w_phaseInc  = wet_valid;
        // Waiting before the first beat is fine; a gap once beats have begun is a protocol error.
        if (wet_valid) begin
          if (r_phaseCnt == CNT_W'(ROWS - 1)) w_nextState = SA_SETTLE;
        end else if (r_phaseCnt != '0) begin
          w_setErr    = 1'b1;
          w_nextState = SA_IDLE;
        end
      end
      SA_SETTLE: begin
        w_phaseInc = 1'b1;
        if (r_phaseCnt == CNT_W'(ROWS - 1)) w_nextState = SA_COMPUTE;
      end
      SA_COMPUTE: begin
        w_actReady = (r_actCnt < r_len);
        if (act_valid && w_actReady && (r_actCnt == r_len - LEN_W'(1))) begin
          w_nextState = SA_DRAIN;
        end
      end
      SA_DRAIN: begin
        w_phaseInc = 1'b1;
        if (r_phaseCnt == CNT_W'(ROWS)) w_nextState = SA_DONE;
      end
      SA_DONE: begin
        w_nextState = SA_IDLE;
      end
      default: begin
        w_nextState = SA_IDLE;
      end
    endcase
    if (abort) begin
      w_nextState = SA_IDLE;
      w_startAcc  = 1'b0;
      w_setErr    = 1'b0;
    end
  end

  // One phase counter serves beat counting, settle and drain; it restarts on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phaseCnt <= '0;
    end else if (w_nextState != r_state) begin
      r_phaseCnt <= '0;
    end else if (w_phaseInc) begin
      r_phaseCnt <= r_phaseCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_actCnt <= '0;
      r_len    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_startAcc) begin
        r_actCnt <= '0;
        r_len    <= len;
      end else if (w_en0) begin
        r_actCnt <= r_actCnt + LEN_W'(1);
      end
      if (w_startAcc) begin
        r_err <= 1'b0;
      end else if (w_setErr) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_en0 = act_valid && w_actReady;

  sa_enable_skew #(
    .ROWS(ROWS)
  ) u_skew (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (abort),
    .i_en0    (w_en0),
    .o_enable (pe_mac_enable),
    .o_last   (out_valid)
  );

  assign wet_ready       = w_wetReady;
  assign act_ready       = w_actReady;
  assign pe_clear_weight = w_clear;
  assign pe_weight_sel   = w_weightSel;
  assign busy            = (r_state != SA_IDLE);
  assign done            = (r_state == SA_DONE) && !abort;
  assign err             = r_err;

`ifdef SA_CTRL_PERF_CNT_EN
  logic [SA_PERF_W-1:0] r_perfCycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perfCycles <= '0;
    end else if (w_startAcc) begin
      r_perfCycles <= '0;
    end else if ((r_state != SA_IDLE) && (r_perfCycles != '1)) begin
      r_perfCycles <= r_perfCycles + SA_PERF_W'(1);
    end
  end

  assign perf_cycles = r_perfCycles;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: a cycle timeline of expected outputs is
// built from job-level rules, then replayed against the DUT and compared every cycle.
module tb_systolic_array_ctrl;
  import sa_pkg::*;

  localparam int ROWS  = 4;
  localparam int LEN_W = 4;
  localparam int MAXC  = 4000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             wetValid;
  logic             wetReady;
  logic             actValid;
  logic             actReady;
  logic             peClearWeight;
  logic             peWeightSel;
  logic [ROWS-1:0]  peMacEnable;
  logic             outValid;
  logic             busy;
  logic             done;
  logic             err;
`ifdef SA_CTRL_PERF_CNT_EN
  logic [31:0]      perfCycles;
`endif

  always #5 clk = ~clk;

  systolic_array_ctrl #(
    .ROWS (ROWS),
    .LEN_W(LEN_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .len            (len),
    .abort          (abort),
    .wet_valid      (wetValid),
    .wet_ready      (wetReady),
    .act_valid      (actValid),
    .act_ready      (actReady),
    .pe_clear_weight(peClearWeight),
    .pe_weight_sel  (peWeightSel),
    .pe_mac_enable  (peMacEnable),
    .out_valid      (outValid),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef SA_CTRL_PERF_CNT_EN
    ,
    .perf_cycles    (perfCycles)
`endif
  );

  typedef struct {
    logic             resetN;
    logic             start;
    logic             abort;
    logic             wetValid;
    logic             actValid;
    logic [LEN_W-1:0] len;
  } stim_t;

  typedef struct {
    logic            busy, done, err, wetReady, actReady, clr, sel, outValid;
    logic [ROWS-1:0] en;
    logic [31:0]     perf;
  } exp_t;

  stim_t       stimQ[$];
  exp_t        expQ[$];
  bit          en0Hist[$];
  int          lastClr = -1;
  logic        errM = 1'b0;
  logic [31:0] perfNext = '0;

  int errors = 0;
  int checks = 0;
  int curT = -1;

  logic [ROWS-1:0] obsEn[MAXC];
  bit              obsClr[MAXC], obsSel[MAXC], obsOv[MAXC], obsDone[MAXC], obsBusy[MAXC];
  logic [31:0]     obsPerf[MAXC];

  function automatic stim_t quiet();
    stim_t s;
    s.resetN   = 1'b1;
    s.start    = 1'b0;
    s.abort    = 1'b0;
    s.wetValid = 1'($urandom_range(1));
    s.actValid = 1'($urandom_range(1));
    s.len      = LEN_W'($urandom);
    return s;
  endfunction

  // Inside a job, start is randomly asserted to show it is ignored while busy.
  function automatic stim_t busyStim();
    stim_t s;
    s       = quiet();
    s.start = 1'($urandom_range(1));
    return s;
  endfunction

  // Append one cycle: enables are the row-0 handshake delayed by row index, out_valid by ROWS.
  task automatic addCycle(input stim_t s, input logic bsy, input logic dn, input logic wr,
                          input logic ar, input logic clr, input logic sel);
    exp_t e;
    int   t;
    logic en0;
    logic acc;
    t   = expQ.size();
    en0 = s.actValid & ar;
    acc = s.resetN & !bsy & s.start & !s.abort;
    if (!s.resetN) begin
      lastClr = t;
      errM    = 1'b0;
    end
    en0Hist.push_back(en0);
    e.busy     = bsy;
    e.done     = dn;
    e.err      = errM;
    e.wetReady = wr;
    e.actReady = ar;
    e.clr      = clr;
    e.sel      = sel;
    e.perf     = s.resetN ? perfNext : 32'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) e.en[r] = en0;
      else        e.en[r] = (t - r > lastClr) ? en0Hist[t - r] : 1'b0;
    end
    e.outValid = (t - ROWS > lastClr) ? en0Hist[t - ROWS] : 1'b0;
    if (!s.resetN || acc)                  perfNext = 32'd0;
    else if (bsy && e.perf != 32'hFFFF_FFFF) perfNext = e.perf + 32'd1;
    else                                    perfNext = e.perf;
    if (s.abort) lastClr = t;
    stimQ.push_back(s);
    expQ.push_back(e);
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) addCycle(quiet(), 0, 0, 0, 0, 0, 0);
  endtask

  task automatic addReset(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s        = quiet();
      s.resetN = 1'b0;
      addCycle(s, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // errBeats: beats delivered before wet_valid drops (-1 none); abortAt/resetAt: compute/drain cycle index (-1 none).
  task automatic runJob(input int L, input int wetDelay, input int errBeats, input logic [31:0] pat,
                        input int patLen, input int actPct, input int abortAt, input int resetAt);
    stim_t s;
    int    acc;
    int    k;
    logic  av;
    s       = quiet();
    s.start = 1'b1;
    s.len   = LEN_W'(L);
    addCycle(s, 0, 0, 0, 0, 0, 0);
    errM = 1'b0;
    if (L == 0) begin
      addCycle(busyStim(), 1, 1, 0, 0, 0, 0);
      return;
    end
    addCycle(busyStim(), 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < wetDelay; i++) begin
      s = busyStim(); s.wetValid = 1'b0;
      addCycle(s, 1, 0, 1, 0, 0, 0);
    end
    for (int b = 0; b < ROWS; b++) begin
      s = busyStim();
      if (b == errBeats) begin
        s.wetValid = 1'b0;
        addCycle(s, 1, 0, 1, 0, 0, 0);
        errM = 1'b1;
        return;
      end
      s.wetValid = 1'b1;
      addCycle(s, 1, 0, 1, 0, 0, 1);
    end
    for (int i = 0; i < ROWS; i++) addCycle(busyStim(), 1, 0, 0, 0, 0, 0);
    acc = 0;
    k   = 0;
    while (acc < L) begin
      s          = busyStim();
      av         = (k < patLen) ? pat[k] : 1'($urandom_range(99) < actPct);
      s.actValid = av;
      s.abort    = (k == abortAt);
      addCycle(s, 1, 0, 0, 1, 0, 0);
      if (s.abort) return;
      acc += int'(av);
      k++;
    end
    for (int i = 0; i <= ROWS; i++) begin
      s = busyStim();
      if (i == resetAt) begin
        s.resetN = 1'b0;
        addCycle(s, 0, 0, 0, 0, 0, 0);
        return;
      end
      addCycle(s, 1, 0, 0, 0, 0, 0);
    end
    addCycle(busyStim(), 1, 1, 0, 0, 0, 0);
  endtask

  task automatic compareField(input string name, input int t, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, t, got, want);
    end
  endtask

  task automatic applyStimulus(input int t);
    reset_n  = stimQ[t].resetN;
    start    = stimQ[t].start;
    abort    = stimQ[t].abort;
    wetValid = stimQ[t].wetValid;
    actValid = stimQ[t].actValid;
    len      = stimQ[t].len;
  endtask

  task automatic checkOutput(input int t);
    exp_t e;
    e = expQ[t];
    compareField("busy", t, 32'(busy), 32'(e.busy));
    compareField("done", t, 32'(done), 32'(e.done));
    compareField("err", t, 32'(err), 32'(e.err));
    compareField("wet_ready", t, 32'(wetReady), 32'(e.wetReady));
    compareField("act_ready", t, 32'(actReady), 32'(e.actReady));
    compareField("pe_clear_weight", t, 32'(peClearWeight), 32'(e.clr));
    compareField("pe_weight_sel", t, 32'(peWeightSel), 32'(e.sel));
    compareField("pe_mac_enable", t, 32'(peMacEnable), 32'(e.en));
    compareField("out_valid", t, 32'(outValid), 32'(e.outValid));
`ifdef SA_CTRL_PERF_CNT_EN
    compareField("perf_cycles", t, perfCycles, e.perf);
    obsPerf[t] = perfCycles;
`endif
    obsEn[t]   = peMacEnable;
    obsClr[t]  = peClearWeight;
    obsSel[t]  = peWeightSel;
    obsOv[t]   = outValid;
    obsDone[t] = done;
    obsBusy[t] = busy;
  endtask

  always @(negedge clk) begin
    if (curT >= 0) checkOutput(curT);
  end

  int s35, s0, s38;
  int nSel, nOv, nDone, nBusy;
  int jL, jDelay, jErr, jAbort, jReset;

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    wetValid = 1'b0;
    actValid = 1'b0;
    len      = '0;

    addReset(3);
    addIdle(2);
    s35 = expQ.size();
    runJob(3, 0, -1, 32'h7, 3, 100, -1, -1);
    addIdle(2);
    s0 = expQ.size();
    runJob(0, 0, -1, 32'h0, 0, 100, -1, -1);
    addIdle(1);
    runJob(2, 1, 2, 32'h0, 0, 100, -1, -1);
    addIdle(2);
    runJob(2, 0, -1, 32'h0, 0, 60, -1, -1);
    addIdle(1);
    s38 = expQ.size();
    runJob(3, 0, -1, 32'b11001, 5, 100, -1, -1);
    addIdle(1);
    runJob(5, 0, -1, 32'h1F, 5, 100, 2, -1);
    addIdle(1);
    runJob(2, 2, -1, 32'h0, 0, 70, -1, -1);
    runJob(2, 0, -1, 32'h0, 0, 100, -1, 1);
    runJob(3, 0, -1, 32'h0, 0, 50, -1, -1);
    addIdle(1);
    runJob(15, 0, -1, 32'h7FFF, 15, 100, -1, -1);
    addIdle(2);
    for (int j = 0; j < 30; j++) begin
      jL     = $urandom_range(6);
      jDelay = $urandom_range(2);
      jErr   = ($urandom_range(4) == 0) ? int'($urandom_range(ROWS - 1, 1)) : -1;
      jAbort = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1;
      jReset = ($urandom_range(7) == 0) ? int'($urandom_range(ROWS)) : -1;
      runJob(jL, jDelay, jErr, 32'h0, 0, 55, jAbort, jReset);
      addIdle($urandom_range(2));
    end
    addIdle(3);

    if (stimQ.size() > MAXC) begin
      $display("[TB] FAIL timeline: got %0d cycles, limit %0d", stimQ.size(), MAXC);
      $fatal(1, "[TB] timeline too long");
    end

    for (int t = 0; t < stimQ.size(); t++) begin
      @(posedge clk);
      #1;
      applyStimulus(t);
      curT = t;
    end
    @(posedge clk);
    #1;
    curT = -1;

    // Hand-derived timeline of a ROWS=4, len=3 contiguous job started at cycle s35.
    compareField("job35 clear@1", s35 + 1, 32'(obsClr[s35 + 1]), 32'd1);
    compareField("job35 stair0", s35 + 10, 32'(obsEn[s35 + 10]), 32'b0001);
    compareField("job35 stair1", s35 + 11, 32'(obsEn[s35 + 11]), 32'b0011);
    compareField("job35 stair2", s35 + 12, 32'(obsEn[s35 + 12]), 32'b0111);
    compareField("job35 stair3", s35 + 13, 32'(obsEn[s35 + 13]), 32'b1110);
    compareField("job35 first out_valid", s35 + 14, 32'(obsOv[s35 + 14]), 32'd1);
    compareField("job35 done@18", s35 + 18, 32'(obsDone[s35 + 18]), 32'd1);
    nSel = 0; nOv = 0; nDone = 0; nBusy = 0;
    for (int t = s35; t < s35 + 20; t++) begin
      nSel  += int'(obsSel[t]);
      nOv   += int'(obsOv[t]);
      nDone += int'(obsDone[t]);
      nBusy += int'(obsBusy[t]);
    end
    compareField("job35 sel cycles", s35, 32'(nSel), 32'd4);
    compareField("job35 out_valid pulses", s35, 32'(nOv), 32'd3);
    compareField("job35 done pulses", s35, 32'(nDone), 32'd1);
    compareField("job35 busy cycles", s35, 32'(nBusy), 32'd18);
`ifdef SA_CTRL_PERF_CNT_EN
    compareField("job35 perf_cycles", s35 + 19, obsPerf[s35 + 19], 32'd18);
`endif
    compareField("len0 done@1", s0 + 1, 32'(obsDone[s0 + 1]), 32'd1);
    nOv = 0;
    for (int t = s38; t < s38 + 25; t++) nOv += int'(obsOv[t]);
    compareField("bubble job out_valid pulses", s38, 32'(nOv), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
